// File: rtl/gpr_ctx_engine.sv
// Purpose: GPR context save/restore engine; streams GPRs 0..NUM_REGS-1 to/from a contiguous memory block.
// Latency: save = NUM_REGS busy cycles, restore = 2*NUM_REGS busy cycles (no wait states); done pulses the cycle after.
// Backpressure: mem_ready=0 holds SAVE/RD with all outputs stable; requests arriving while busy are dropped.
module gpr_ctx_engine #(
  parameter int NUM_REGS = 8,
  parameter int DATA_W   = 8,
  parameter int REG_AW   = 3,
  parameter int MEM_AW   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              save_req,
  input  logic              restore_req,
  input  logic [MEM_AW-1:0] base_addr,
  output logic              busy,
  output logic              done,
  output logic [REG_AW-1:0] gpr_r_addr,
  input  logic [DATA_W-1:0] gpr_r_data,
  output logic              gpr_w_enable,
  output logic [REG_AW-1:0] gpr_w_addr,
  output logic [DATA_W-1:0] gpr_w_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SAVE = 2'd1,
    RD   = 2'd2,
    WB   = 2'd3
  } state_t;

  localparam logic [REG_AW-1:0] LAST_IDX = REG_AW'(NUM_REGS - 1);

  state_t            state;
  logic [REG_AW-1:0] idx;
  logic [MEM_AW-1:0] base;
  logic [REG_AW-1:0] idx_nxt;
  logic [MEM_AW-1:0] addr_nxt;

  // Next register index and its memory slot; the slot address wraps modulo 2^MEM_AW.
  assign idx_nxt  = idx + REG_AW'(1);
  assign addr_nxt = base + MEM_AW'(idx_nxt);

  // The register file answers combinationally, so save data is forwarded straight through;
  // gating on mem_we keeps the bus at zero outside SAVE and while reset is held.
  assign mem_wdata = mem_we ? gpr_r_data : '0;

  // Single FSM with registered outputs: every output is computed together with the state it belongs to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      base         <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      gpr_r_addr   <= '0;
      gpr_w_enable <= 1'b0;
      gpr_w_addr   <= '0;
      gpr_w_data   <= '0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
    end else begin
      // Pulses last one cycle unless re-raised below.
      done         <= 1'b0;
      gpr_w_enable <= 1'b0;
      case (state)
        IDLE: begin
          // Save wins when both requests arrive together.
          if (save_req) begin
            state      <= SAVE;
            base       <= base_addr;
            idx        <= '0;
            busy       <= 1'b1;
            mem_req    <= 1'b1;
            mem_we     <= 1'b1;
            gpr_r_addr <= '0;
            mem_addr   <= base_addr;
          end else if (restore_req) begin
            state      <= RD;
            base       <= base_addr;
            idx        <= '0;
            busy       <= 1'b1;
            mem_req    <= 1'b1;
            mem_we     <= 1'b0;
            gpr_r_addr <= '0;
            mem_addr   <= base_addr;
          end
        end
        SAVE: begin
          if (mem_ready) begin
            if (idx == LAST_IDX) begin
              state      <= IDLE;
              idx        <= '0;
              busy       <= 1'b0;
              done       <= 1'b1;
              mem_req    <= 1'b0;
              mem_we     <= 1'b0;
              gpr_r_addr <= '0;
              mem_addr   <= '0;
            end else begin
              idx        <= idx_nxt;
              gpr_r_addr <= idx_nxt;
              mem_addr   <= addr_nxt;
            end
          end
        end
        RD: begin
          // Capture the returned word; the write strobe fires during WB only.
          if (mem_ready) begin
            state        <= WB;
            gpr_w_data   <= mem_rdata;
            gpr_w_addr   <= idx;
            gpr_w_enable <= 1'b1;
            mem_req      <= 1'b0;
          end
        end
        WB: begin
          if (idx == LAST_IDX) begin
            state    <= IDLE;
            idx      <= '0;
            busy     <= 1'b0;
            done     <= 1'b1;
            mem_addr <= '0;
          end else begin
            state    <= RD;
            idx      <= idx_nxt;
            mem_req  <= 1'b1;
            mem_addr <= addr_nxt;
          end
        end
        default: begin
          state   <= IDLE;
          busy    <= 1'b0;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gpr_ctx_engine.sv
// Directed + randomized bench for gpr_ctx_engine: register file and memory modelled as arrays,
// transfers logged at the negative edge and compared against expectations built from the save/restore rules.
module tb_gpr_ctx_engine;
  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       save_req, restore_req;
  logic [7:0] base_addr;
  logic       busy, done;
  logic [2:0] gpr_r_addr;
  logic [7:0] gpr_r_data;
  logic       gpr_w_enable;
  logic [2:0] gpr_w_addr;
  logic [7:0] gpr_w_data;
  logic       mem_req, mem_we;
  logic [7:0] mem_addr, mem_wdata;
  logic       mem_ready;
  logic [7:0] mem_rdata;

  logic [7:0] gpr [N];
  logic [7:0] mem [256];

  int checks = 0;
  int errors = 0;

  // Log state written by the negedge monitor
  int rdy_mode = 0;
  int stall_run = 0;
  int cyc = 0;
  int busy_cnt, done_cnt, stall_cyc, stall_viol, rule_viol, first_done, last_busy;
  logic        prev_stall = 1'b0;
  logic [20:0] prev_bus = '0;
  logic [7:0]  wr_addr_q[$], wr_data_q[$], rd_addr_q[$], gw_data_q[$];
  logic [2:0]  gw_addr_q[$];
  int          gw_cyc_q[$];

  gpr_ctx_engine #(.NUM_REGS(8), .DATA_W(8), .REG_AW(3), .MEM_AW(8)) dut (
    .clk(clk), .rst(rst), .save_req(save_req), .restore_req(restore_req), .base_addr(base_addr),
    .busy(busy), .done(done), .gpr_r_addr(gpr_r_addr), .gpr_r_data(gpr_r_data),
    .gpr_w_enable(gpr_w_enable), .gpr_w_addr(gpr_w_addr), .gpr_w_data(gpr_w_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign gpr_r_data = gpr[gpr_r_addr];
  assign mem_rdata  = mem[mem_addr];

  // Drive mem_ready for the coming edge and log everything that edge will commit.
  always @(negedge clk) begin
    if (rst) begin
      mem_ready  = 1'b0;
      prev_stall = 1'b0;
      stall_run  = 0;
    end else begin
      case (rdy_mode)
        0: mem_ready = 1'b1;
        1: mem_ready = ($urandom_range(0, 3) != 0);
        default: begin
          if (!mem_req) begin
            mem_ready = 1'b0; stall_run = 0;
          end else if (stall_run < 2) begin
            mem_ready = 1'b0; stall_run++;
          end else begin
            mem_ready = 1'b1; stall_run = 0;
          end
        end
      endcase
      cyc++;
      if (busy) begin busy_cnt++; last_busy = cyc; end
      if (done) begin done_cnt++; if (first_done < 0) first_done = cyc; end
      if (prev_stall && ({mem_req, mem_we, mem_addr, mem_wdata, gpr_r_addr} !== prev_bus)) stall_viol++;
      prev_stall = mem_req && !mem_ready;
      prev_bus   = {mem_req, mem_we, mem_addr, mem_wdata, gpr_r_addr};
      if (mem_req && !mem_ready) stall_cyc++;
      if (gpr_w_enable && (mem_we || mem_req)) rule_viol++;
      if (mem_we && !mem_req) rule_viol++;
      if (mem_req && mem_ready) begin
        if (mem_we) begin
          mem[mem_addr] = mem_wdata;
          wr_addr_q.push_back(mem_addr);
          wr_data_q.push_back(mem_wdata);
        end else begin
          rd_addr_q.push_back(mem_addr);
        end
      end
      if (gpr_w_enable) begin
        gpr[gpr_w_addr] = gpr_w_data;
        gw_addr_q.push_back(gpr_w_addr);
        gw_data_q.push_back(gpr_w_data);
        gw_cyc_q.push_back(cyc);
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete();
    gw_addr_q.delete(); gw_data_q.delete(); gw_cyc_q.delete();
    busy_cnt = 0; done_cnt = 0; stall_cyc = 0; stall_viol = 0; rule_viol = 0;
    first_done = -1; last_busy = -1;
  endtask

  task automatic start(input logic s, input logic r, input logic [7:0] b);
    save_req = s; restore_req = r; base_addr = b;
    @(posedge clk); #1;
    save_req = 1'b0; restore_req = 1'b0;
  endtask

  // Bounded wait for done, then one more cycle so the monitor has logged the done cycle.
  task automatic wait_done(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (done) begin seen = 1'b1; break; end
      @(posedge clk); #1;
    end
    chk({tag, "_done_seen"}, seen, 1);
    @(posedge clk); #1;
  endtask

  function automatic logic [34:0] all_outs();
    return {busy, done, gpr_w_enable, mem_req, mem_we, gpr_r_addr, gpr_w_addr, gpr_w_data, mem_addr, mem_wdata};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] snap [N];
    logic [7:0] b;
    int bad;
    rst = 1'b0; save_req = 1'b0; restore_req = 1'b0; base_addr = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i ^ 8'h5A);
    for (int i = 0; i < N; i++) gpr[i] = 8'(8'h10 + i);

    // Reset state
    #2 rst = 1'b1;
    #1 chk("reset_outputs", all_outs(), 0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 chk("idle_outputs", all_outs(), 0);

    // Save, ready always high, base 0x40
    rdy_mode = 0;
    clear_logs();
    start(1'b1, 1'b0, 8'h40);
    wait_done("t1");
    chk("t1_nwrites", wr_addr_q.size(), 8);
    for (int i = 0; i < N && i < wr_addr_q.size(); i++)
      chk($sformatf("t1_wr%0d", i), {wr_addr_q[i], wr_data_q[i]}, {8'(8'h40 + i), 8'(8'h10 + i)});
    chk("t1_busy_cycles", busy_cnt, 8);
    chk("t1_done_cycles", done_cnt, 1);
    chk("t1_done_gap", first_done - last_busy, 1);
    chk("t1_no_reads_no_gpr_writes", rd_addr_q.size() + gw_addr_q.size(), 0);
    chk("t1_rules", rule_viol, 0);

    // Restore from 0x80
    for (int i = 0; i < N; i++) begin mem[8'h80 + i] = 8'(8'hA0 + i); gpr[i] = 8'hEE; end
    clear_logs();
    start(1'b0, 1'b1, 8'h80);
    wait_done("t2");
    chk("t2_ngpr_writes", gw_addr_q.size(), 8);
    chk("t2_nreads", rd_addr_q.size(), 8);
    for (int i = 0; i < N && i < gw_addr_q.size() && i < rd_addr_q.size(); i++)
      chk($sformatf("t2_wb%0d", i), {5'd0, gw_addr_q[i], gw_data_q[i], rd_addr_q[i]},
          {8'(i), 8'(8'hA0 + i), 8'(8'h80 + i)});
    bad = 0;
    for (int i = 1; i < gw_cyc_q.size(); i++) if (gw_cyc_q[i] - gw_cyc_q[i-1] != 2) bad++;
    chk("t2_wb_every_other_cycle", bad, 0);
    chk("t2_busy_cycles", busy_cnt, 16);
    chk("t2_done_cycles", done_cnt, 1);
    chk("t2_done_gap", first_done - last_busy, 1);
    chk("t2_no_mem_writes", wr_addr_q.size(), 0);
    chk("t2_rules", rule_viol, 0);

    // Save with address wrap and two wait states before each accept
    rdy_mode = 2;
    for (int i = 0; i < N; i++) gpr[i] = 8'($urandom);
    clear_logs();
    start(1'b1, 1'b0, 8'hFC);
    wait_done("t3");
    chk("t3_nwrites", wr_addr_q.size(), 8);
    for (int i = 0; i < N && i < wr_addr_q.size(); i++)
      chk($sformatf("t3_wr%0d", i), {wr_addr_q[i], wr_data_q[i]}, {8'(8'hFC + i), gpr[i]});
    chk("t3_busy_cycles", busy_cnt, 24);
    chk("t3_stall_cycles", stall_cyc, 16);
    chk("t3_stall_stable", stall_viol, 0);
    chk("t3_done_cycles", done_cnt, 1);

    // Both requests together, restore pulses while busy, back-to-back save
    rdy_mode = 0;
    clear_logs();
    start(1'b1, 1'b1, 8'h20);
    @(posedge clk); #1 restore_req = 1'b1;
    @(posedge clk); #1 restore_req = 1'b0;
    @(posedge clk); #1 restore_req = 1'b1;
    @(posedge clk); #1 restore_req = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin @(posedge clk); #1; end
    chk("t4_first_done", done, 1);
    save_req = 1'b1; base_addr = 8'h30;
    @(posedge clk); #1 save_req = 1'b0;
    chk("t4_b2b_busy", busy, 1);
    wait_done("t4");
    chk("t4_nreads", rd_addr_q.size(), 0);
    chk("t4_nwrites", wr_addr_q.size(), 16);
    bad = 0;
    for (int i = 0; i < wr_addr_q.size(); i++)
      if (wr_addr_q[i] !== ((i < N) ? 8'(8'h20 + i) : 8'(8'h30 + i - N))) bad++;
    chk("t4_addresses", bad, 0);
    chk("t4_busy_cycles", busy_cnt, 16);
    chk("t4_done_cycles", done_cnt, 2);

    // Asynchronous reset after the third restore write-back
    for (int i = 0; i < N; i++) begin gpr[i] = 8'(8'h50 + i); mem[8'h90 + i] = 8'(8'hC0 + i); end
    clear_logs();
    start(1'b0, 1'b1, 8'h90);
    for (int i = 0; i < 100 && gw_addr_q.size() < 3; i++) begin @(posedge clk); #1; end
    chk("t5_three_wb_before_reset", gw_addr_q.size(), 3);
    #2 rst = 1'b1;
    #1 chk("t5_async_reset_outputs", all_outs(), 0);
    for (int i = 0; i < N; i++)
      chk($sformatf("t5_gpr%0d", i), gpr[i], (i < 3) ? 8'(8'hC0 + i) : 8'(8'h50 + i));
    @(posedge clk); #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("t5_no_done_after_reset", done_cnt, 0);
    chk("t5_idle_after_reset", {busy, mem_req, gpr_w_enable}, 0);

    // Randomized round trip with mem_ready toggling
    rdy_mode = 1;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < N; i++) begin gpr[i] = 8'($urandom); snap[i] = gpr[i]; end
      b = 8'($urandom);
      clear_logs();
      start(1'b1, 1'b0, b);
      wait_done($sformatf("t6_save%0d", r));
      chk($sformatf("t6_save_busy%0d", r), busy_cnt, N + stall_cyc);
      chk($sformatf("t6_save_stable%0d", r), stall_viol, 0);
      for (int i = 0; i < N; i++) gpr[i] = ~snap[i];
      clear_logs();
      start(1'b0, 1'b1, b);
      wait_done($sformatf("t6_rest%0d", r));
      chk($sformatf("t6_rest_busy%0d", r), busy_cnt, 2 * N + stall_cyc);
      bad = 0;
      for (int i = 0; i < N; i++) if (gpr[i] !== snap[i]) bad++;
      chk($sformatf("t6_roundtrip%0d", r), bad, 0);
      chk($sformatf("t6_rules%0d", r), rule_viol, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
